// File: rtl/video_shifter_pkg.sv
// Shared constants for the video pixel serializer: plane bit positions, palette
// sizing and reset contents, and the blank/sync pipeline description.
package video_shifter_pkg;

  localparam int PLANE_B     = 0;
  localparam int PLANE_R     = 1;
  localparam int PLANE_G     = 2;
  localparam int NUM_PLANES  = 3;
  localparam int PAL_ENTRIES = 1 << NUM_PLANES;
  localparam int PIPE_DEPTH  = 3;

  typedef struct packed {
    logic blank_n;
    logic hsync_n;
    logic vsync_n;
  } sync_ctrl_t;

  // Blanked with both syncs inactive, so nothing reaches the DAC out of reset.
  localparam sync_ctrl_t SYNC_RESET = '{blank_n: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  function automatic logic [NUM_PLANES-1:0] pal_reset_value(input int i);
    return NUM_PLANES'(i);
  endfunction

endpackage

// File: rtl/video_palette.sv
// Eight-entry digital palette register file: one write port, one asynchronous
// read port, identity contents after reset.
module video_palette
  import video_shifter_pkg::*;
#(
  parameter int COLOR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [NUM_PLANES-1:0] wa,
  input  logic [COLOR_W-1:0]    wd,
  input  logic [NUM_PLANES-1:0] ra,
  output logic [COLOR_W-1:0]    rd
);

  logic [COLOR_W-1:0] entry [PAL_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        entry[i] <= COLOR_W'(pal_reset_value(i));
      end
    end else if (we) begin
      entry[wa] <= wd;
    end
  end

  // Read is combinational so the registered lookup sees the pre-write value.
  assign rd = entry[ra];

endmodule

// File: rtl/video_shifter.sv
// Pixel serializer: three plane shift registers feed a masked index stage and a
// palette lookup stage, with blank/sync delayed through a matching pipe.
module video_shifter
  import video_shifter_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COLOR_W = 3
) (
  input  logic                  CLKSYS,
  input  logic                  SRESET,
  input  logic                  SFTCLK_EN,
  input  logic                  SFTLODn,
  input  logic [DATA_W-1:0]     VDATA_B,
  input  logic [DATA_W-1:0]     VDATA_R,
  input  logic [DATA_W-1:0]     VDATA_G,
  input  logic                  SBLANKn,
  input  logic                  SHSYNCn,
  input  logic                  SVSYNCn,
  input  logic                  MPAGE_WE,
  input  logic [NUM_PLANES-1:0] MPAGE_D,
  input  logic                  PAL_WE,
  input  logic [NUM_PLANES-1:0] PAL_A,
  input  logic [COLOR_W-1:0]    PAL_D,
  output logic [COLOR_W-1:0]    VID_RGB,
  output logic                  VID_BLANKn,
  output logic                  VID_HSYNCn,
  output logic                  VID_VSYNCn
);

  logic [DATA_W-1:0]     shift_b_p0;
  logic [DATA_W-1:0]     shift_r_p0;
  logic [DATA_W-1:0]     shift_g_p0;
  logic [NUM_PLANES-1:0] plane_msb;
  logic [NUM_PLANES-1:0] mask;
  logic [NUM_PLANES-1:0] idx_p1;
  logic [COLOR_W-1:0]    pal_rd;
  sync_ctrl_t            ctrl_pipe [PIPE_DEPTH];

  always_comb begin
    plane_msb          = '0;
    plane_msb[PLANE_B] = shift_b_p0[DATA_W-1];
    plane_msb[PLANE_R] = shift_r_p0[DATA_W-1];
    plane_msb[PLANE_G] = shift_g_p0[DATA_W-1];
  end

  always_ff @(posedge CLKSYS) begin
    if (SRESET) begin
      mask <= '0;
    end else if (MPAGE_WE) begin
      mask <= MPAGE_D;
    end
  end

  video_palette #(
    .COLOR_W (COLOR_W)
  ) u_palette (
    .clk (CLKSYS),
    .rst (SRESET),
    .we  (PAL_WE),
    .wa  (PAL_A),
    .wd  (PAL_D),
    .ra  (idx_p1),
    .rd  (pal_rd)
  );

  always_ff @(posedge CLKSYS) begin
    if (SRESET) begin
      shift_b_p0 <= '0;
      shift_r_p0 <= '0;
      shift_g_p0 <= '0;
      idx_p1     <= '0;
      VID_RGB    <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        ctrl_pipe[i] <= SYNC_RESET;
      end
    end else if (SFTCLK_EN) begin
      // Stage 1: load or shift MSB-first with zero fill
      if (!SFTLODn) begin
        shift_b_p0 <= VDATA_B;
        shift_r_p0 <= VDATA_R;
        shift_g_p0 <= VDATA_G;
      end else begin
        shift_b_p0 <= {shift_b_p0[DATA_W-2:0], 1'b0};
        shift_r_p0 <= {shift_r_p0[DATA_W-2:0], 1'b0};
        shift_g_p0 <= {shift_g_p0[DATA_W-2:0], 1'b0};
      end

      // Stage 2: masked palette index
      idx_p1 <= plane_msb & ~mask;

      // Stage 3: palette lookup, forced to 0 by the blank aligned with this index
      VID_RGB <= ctrl_pipe[PIPE_DEPTH-2].blank_n ? pal_rd : '0;

      ctrl_pipe[0] <= '{blank_n: SBLANKn, hsync_n: SHSYNCn, vsync_n: SVSYNCn};
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        ctrl_pipe[i] <= ctrl_pipe[i-1];
      end
    end
  end

  assign VID_BLANKn = ctrl_pipe[PIPE_DEPTH-1].blank_n;
  assign VID_HSYNCn = ctrl_pipe[PIPE_DEPTH-1].hsync_n;
  assign VID_VSYNCn = ctrl_pipe[PIPE_DEPTH-1].vsync_n;

endmodule
